// File: rtl/vedic_mac4_acc.sv
// Streaming dot-product engine: 4x4 Vedic multiplier feeding a saturating/wrapping accumulator.
// Three-stage pipeline (operand, product, accumulate) with valid/ready on both sides.

module VM_csa_opti (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);

   function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
      logic t, u, h, c;
      t = x[1] & y[0];
      u = x[0] & y[1];
      h = x[1] & y[1];
      c = t & u;
      return {h & c, h ^ c, t ^ u, x[0] & y[0]};
   endfunction

   logic [3:0] q0, q1, q2, q3;
   logic [7:0] x, y, z, w, s1, c1, s2, c2, m1, m2;

   // Four partial products reduced by two carry-save levels and one final adder.
   always_comb begin
      q0 = vm2(a[1:0], b[1:0]);
      q1 = vm2(a[3:2], b[1:0]);
      q2 = vm2(a[1:0], b[3:2]);
      q3 = vm2(a[3:2], b[3:2]);
      x  = {4'b0, q0};
      y  = {2'b0, q1, 2'b0};
      z  = {2'b0, q2, 2'b0};
      w  = {q3, 4'b0};
      s1 = x ^ y ^ z;
      m1 = (x & y) | (x & z) | (y & z);
      c1 = {m1[6:0], 1'b0};
      s2 = s1 ^ c1 ^ w;
      m2 = (s1 & c1) | (s1 & w) | (c1 & w);
      c2 = {m2[6:0], 1'b0};
      p  = s2 + c2;
   end

endmodule

module vedic_mac4_acc #(
   parameter int unsigned ACC_W = 16,
   parameter int unsigned CNT_W = 8,
   parameter bit          SAT   = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_a,
   input  logic [3:0]       in_b,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic [CNT_W-1:0] out_cnt,
   output logic             out_ovf
);

   logic             stall;
   logic             s1_v_q, s1_last_q, s2_v_q, s2_last_q;
   logic [3:0]       s1_a_q, s1_b_q;
   logic [7:0]       prod, s2_prod_q;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [ACC_W:0]   sum;

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   VM_csa_opti u_mul (
      .a (s1_a_q),
      .b (s1_b_q),
      .p (prod)
   );

   always_comb begin
      sum   = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, s2_prod_q};
      acc_d = sum[ACC_W-1:0];
      ovf_d = ovf_q;
      if (sum[ACC_W]) begin
         ovf_d = 1'b1;
         if (SAT) acc_d = {ACC_W{1'b1}};
      end
      cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v_q    <= 1'b0;
         s1_last_q <= 1'b0;
         s1_a_q    <= '0;
         s1_b_q    <= '0;
         s2_v_q    <= 1'b0;
         s2_last_q <= 1'b0;
         s2_prod_q <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         out_valid <= 1'b0;
         out_acc   <= '0;
         out_cnt   <= '0;
         out_ovf   <= 1'b0;
      end else if (!stall) begin
         s1_v_q <= in_valid;
         if (in_valid) begin
            s1_a_q    <= in_a;
            s1_b_q    <= in_b;
            s1_last_q <= in_last;
         end
         s2_v_q    <= s1_v_q;
         s2_prod_q <= prod;
         s2_last_q <= s1_last_q;
         // Not stalled implies any pending result is transferring this edge.
         out_valid <= s2_v_q & s2_last_q;
         if (s2_v_q) begin
            if (s2_last_q) begin
               out_acc <= acc_d;
               out_cnt <= cnt_d;
               out_ovf <= ovf_d;
               acc_q   <= '0;
               cnt_q   <= '0;
               ovf_q   <= 1'b0;
            end else begin
               acc_q <= acc_d;
               cnt_q <= cnt_d;
               ovf_q <= ovf_d;
            end
         end
      end
   end

endmodule

// File: tb/tb_vedic_mac4_acc.sv
// Bench for vedic_mac4_acc: three instances (16-bit sat, 8-bit sat, 8-bit wrap) share stimulus
// and are checked against a behavioural scoreboard plus directed timing checks.

module tb_vedic_mac4_acc;

   logic       clk = 1'b0;
   logic       rst, in_valid, in_last, out_ready;
   logic [3:0] in_a, in_b;
   logic [2:0] in_ready, out_valid, out_ovf;
   logic [7:0] out_cnt [3];
   logic [15:0] acc0;
   logic [7:0]  acc1, acc2;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int nres [3];
   int xfer_cyc [$];
   logic [24:0] expq0 [$], expq1 [$], expq2 [$];

   longint macc [3];
   int     mcnt [3];
   bit     movf [3];
   int     mw [3] = '{16, 8, 8};
   bit     ms [3] = '{1'b1, 1'b1, 1'b0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   vedic_mac4_acc #(.ACC_W(16), .CNT_W(8), .SAT(1'b1)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .in_a(in_a), .in_b(in_b),
      .in_last(in_last), .out_valid(out_valid[0]), .out_ready(out_ready), .out_acc(acc0),
      .out_cnt(out_cnt[0]), .out_ovf(out_ovf[0]));
   vedic_mac4_acc #(.ACC_W(8), .CNT_W(8), .SAT(1'b1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .in_a(in_a), .in_b(in_b),
      .in_last(in_last), .out_valid(out_valid[1]), .out_ready(out_ready), .out_acc(acc1),
      .out_cnt(out_cnt[1]), .out_ovf(out_ovf[1]));
   vedic_mac4_acc #(.ACC_W(8), .CNT_W(8), .SAT(1'b0)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]), .in_a(in_a), .in_b(in_b),
      .in_last(in_last), .out_valid(out_valid[2]), .out_ready(out_ready), .out_acc(acc2),
      .out_cnt(out_cnt[2]), .out_ovf(out_ovf[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Scoreboard pop on output transfers, then model update on input transfers.
   always @(negedge clk) begin
      logic [24:0] e, got;
      logic        have;
      longint      s, lim;
      for (int i = 0; i < 3; i++) begin
         if (out_valid[i] && out_ready) begin
            have = 1'b0;
            e    = '0;
            case (i)
               0: if (expq0.size() > 0) begin e = expq0.pop_front(); have = 1'b1; end
               1: if (expq1.size() > 0) begin e = expq1.pop_front(); have = 1'b1; end
               default: if (expq2.size() > 0) begin e = expq2.pop_front(); have = 1'b1; end
            endcase
            got = {out_ovf[i], out_cnt[i], (i == 0) ? acc0 : (i == 1) ? {8'b0, acc1} : {8'b0, acc2}};
            chk($sformatf("res_expected_dut%0d", i), {31'b0, have}, 32'd1);
            if (have) begin
               chk($sformatf("acc_dut%0d", i), {16'b0, got[15:0]}, {16'b0, e[15:0]});
               chk($sformatf("cnt_dut%0d", i), {24'b0, got[23:16]}, {24'b0, e[23:16]});
               chk($sformatf("ovf_dut%0d", i), {31'b0, got[24]}, {31'b0, e[24]});
            end
            nres[i]++;
            if (i == 0) xfer_cyc.push_back(cyc);
         end
      end
      if (rst) begin
         for (int i = 0; i < 3; i++) begin macc[i] = 0; mcnt[i] = 0; movf[i] = 1'b0; end
      end else if (in_valid && in_ready[0]) begin
         for (int i = 0; i < 3; i++) begin
            lim = 64'd1 << mw[i];
            s   = macc[i] + longint'(in_a) * longint'(in_b);
            if (s >= lim) begin
               movf[i] = 1'b1;
               macc[i] = ms[i] ? lim - 1 : s - lim;
            end else macc[i] = s;
            mcnt[i] = (mcnt[i] == 255) ? 255 : mcnt[i] + 1;
            if (in_last) begin
               e = {movf[i], 8'(mcnt[i]), 16'(macc[i])};
               case (i)
                  0: expq0.push_back(e);
                  1: expq1.push_back(e);
                  default: expq2.push_back(e);
               endcase
               macc[i] = 0; mcnt[i] = 0; movf[i] = 1'b0;
            end
         end
      end
   end

   task automatic beat(input logic [3:0] a, input logic [3:0] b, input logic last);
      int n;
      in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
      n = 0;
      @(negedge clk);
      while (!in_ready[0] && n < 100) begin @(negedge clk); n++; end
      if (!in_ready[0]) chk("beat_accept_timeout", {31'b0, in_ready[0]}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      for (int i = 0; i < 3; i++) nres[i] = 0;
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", {29'b0, out_valid}, 32'd0);
      chk("rst_in_ready", {29'b0, in_ready}, 32'd7);
      chk("rst_out_acc", {16'b0, acc0}, 32'd0);
      chk("rst_out_cnt", {24'b0, out_cnt[0]}, 32'd0);
      chk("rst_out_ovf", {29'b0, out_ovf}, 32'd0);

      // Latency: single-beat vector 15*15.
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = 4'd15; in_b = 4'd15; in_last = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk); chk("lat_after_e0", {31'b0, out_valid[0]}, 32'd0);
      @(negedge clk); chk("lat_after_e1", {31'b0, out_valid[0]}, 32'd0);
      @(negedge clk);
      chk("lat_after_e2", {31'b0, out_valid[0]}, 32'd1);
      chk("lat_acc", {16'b0, acc0}, 32'd225);
      chk("lat_cnt", {24'b0, out_cnt[0]}, 32'd1);
      chk("lat_ovf", {31'b0, out_ovf[0]}, 32'd0);
      idle(3);

      // Streaming, no gaps, then with gaps: 15+225+0+14 = 254.
      beat(3, 5, 0); beat(15, 15, 0); beat(0, 9, 0); beat(7, 2, 1);
      idle(5);
      beat(3, 5, 0); idle(2); beat(15, 15, 0); idle(1); beat(0, 9, 0); idle(3); beat(7, 2, 1);
      idle(5);

      // Overflow on the 8-bit instances: 450 -> 255 (sat) / 194 (wrap).
      beat(15, 15, 0); beat(15, 15, 1);
      idle(5);

      // Backpressure: hold a result for 6 cycles while a beat is offered.
      out_ready = 1'b0;
      beat(4, 5, 1);
      n = 0;
      @(negedge clk);
      while (!out_valid[0] && n < 20) begin @(negedge clk); n++; end
      chk("stall_result_arrives", {31'b0, out_valid[0]}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = 4'd2; in_b = 4'd2; in_last = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("stall_in_ready", {29'b0, in_ready}, 32'd0);
         chk("stall_out_valid", {31'b0, out_valid[0]}, 32'd1);
         chk("stall_acc_held", {16'b0, acc0}, 32'd20);
         chk("stall_cnt_held", {24'b0, out_cnt[0]}, 32'd1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      beat(2, 2, 0); beat(1, 1, 1);
      idle(6);

      // Back-to-back single-beat vectors must give consecutive results.
      beat(4, 4, 1); beat(1, 3, 1);
      idle(6);
      if (xfer_cyc.size() >= 2)
         chk("b2b_consecutive", 32'(xfer_cyc[$] - xfer_cyc[$-1]), 32'd1);
      else
         chk("b2b_result_count", 32'(xfer_cyc.size()), 32'd2);

      // Partial vector discarded by reset.
      beat(9, 9, 0); beat(9, 9, 0);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      beat(2, 3, 1);
      idle(8);

      for (int i = 0; i < 3; i++) chk($sformatf("result_count_dut%0d", i), 32'(nres[i]), 32'd9);
      chk("queue_drained", 32'(expq0.size() + expq1.size() + expq2.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vedic_mac4_acc.md
Name: vedic_mac4_acc

Overview:
- Streaming multiply-accumulate stage placed directly downstream of the 4x4 Vedic CSA multiplier (VM_csa_opti).
- Each accepted beat carries two 4-bit unsigned operands; the block multiplies them through one internal VM_csa_opti instance and accumulates the 8-bit product.
- When the beat flagged as last has been accumulated, the block emits the dot-product result.
- Used for small vector dot products, for example filter taps.

Parameters:
- ACC_W, 16: accumulator and result width. Must be >= 8.
- CNT_W, 8: width of the term counter.
- SAT, 1: 1 = accumulator saturates at 2^ACC_W-1; 0 = accumulator wraps modulo 2^ACC_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_a  in  4  unsigned operand A
- in_b  in  4  unsigned operand B
- in_last  in  1  beat is the final term of the current vector
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_acc  out  ACC_W  accumulated sum of products
- out_cnt  out  CNT_W  number of terms in the vector
- out_ovf  out  1  overflow occurred in the vector (saturated or wrapped)

Behaviour:
- Reset is synchronous and active-high. On an edge with rst=1, all stage valids, the accumulator, the counter, the ovf flag, out_valid, out_acc, out_cnt and out_ovf are cleared to 0. in_ready is 1 in the cycle after reset.
- A partial vector in flight at reset is discarded. No result is produced for it.
- Handshake on both sides is valid/ready. A transfer occurs on an edge where valid=1 and ready=1.
- in_a, in_b and in_last are sampled only on an input transfer.
- stall = out_valid & ~out_ready. in_ready = ~stall.
- While stall=1, every pipeline register, the accumulator and the output register hold their values.
- Pipeline, with an accepted beat at edge E0:
  - S1 at E0: register a, b, last, and set the S1 valid bit.
  - S2 at E1: register the 8-bit VM_csa_opti product of the S1 operands, plus last and valid.
  - ACC at E2: add the S2 product into the accumulator.
- Latency: for a last beat accepted at E0, out_valid=1 after E2. The result is visible 3 cycles after the beat is presented.
- Accumulate rule, applied when S2 is valid and not stalled:
  - sum = acc + {0, prod}, computed one bit wider than ACC_W.
  - If the carry is set: SAT=1 gives acc_next = all-ones; SAT=0 gives acc_next = sum[ACC_W-1:0]. In both cases ovf_next = 1.
  - Otherwise acc_next = sum[ACC_W-1:0] and ovf_next = ovf.
  - cnt_next = cnt+1, saturating at 2^CNT_W-1. The counter saturates silently and does not set ovf.
- On a last beat:
  - out_acc, out_cnt and out_ovf load acc_next, cnt_next and ovf_next, and out_valid is set to 1.
  - The accumulator, counter and ovf clear to 0 on the same edge.
- Back-to-back vectors: the first beat of the next vector may enter S1 on the same edge a result registers. No bubble is required.
- A new result may load on the same edge the old one transfers (out_valid & out_ready). In that case out_valid stays 1 and the new values appear.
- out_valid clears on an output transfer when no new result loads.
- out_acc, out_cnt and out_ovf are stable while out_valid=1 and out_ready=0.
- Beats with in_last=0 never produce output.
- An empty vector (no beats) produces no output.
- A single-beat vector (first beat has in_last=1) yields out_cnt=1.
- Zero operands still count as terms.
- in_valid=0 cycles between beats do not affect the accumulation.

Test Plan:
- Reset, then one beat a=15, b=15, last=1, out_ready=1 -> out_valid high exactly 3 cycles later; out_acc=225, out_cnt=1, out_ovf=0.
- Streaming beats (3,5), (15,15), (0,9), (7,2, last) with no gaps -> out_acc=254, out_cnt=4, out_ovf=0. Repeat with in_valid gaps inserted -> same result.
- ACC_W=8, SAT=1, beats (15,15), (15,15, last) -> out_acc=255, out_ovf=1. With SAT=0 -> out_acc=194, out_ovf=1.
- out_ready=0 for 6 cycles while a result is pending and beats are offered:
  - in_ready must be 0 throughout.
  - out_* values are held.
  - After release, the next vector (2,2), (1,1, last) gives out_acc=5 with no beat lost or duplicated.
- Two vectors back-to-back, (4,4, last) then (1,3, last), with out_ready=1 -> two consecutive out_valid cycles carrying 16 then 3. The second accumulation starts from 0.
- Assert rst for 1 cycle after beats (9,9), (9,9) with no last, then send (2,3, last) -> exactly one result: out_acc=6, out_cnt=1, out_ovf=0.
